led_fader: RTL and testbench

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 129 ++++++++++++
 tb/tb_led_fader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// led_fader: five-channel PWM LED fader.
// Each LED channel holds a brightness level that either jumps straight to a new on/off
// pattern (snap) or ramps one step per step_tick toward it (fade). Levels drive a shared
// free-running PWM counter comparison; LED outputs are registered.
//
// Ports:
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   pattern    target on/off pattern, bit n -> LEDn
//   pat_valid  pattern offered this cycle
//   pat_snap   1 = jump to pattern, 0 = fade; sampled only on acceptance
//   pat_ready  block idle and able to accept a pattern
//   busy       fade in progress
//   LED4..LED0 PWM-dimmed LED drive, active-high
module led_fader #(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned STEP_DIV = 46875
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] pattern,
  input  logic       pat_valid,
  input  logic       pat_snap,
  output logic       pat_ready,
  output logic       busy,
  output logic       LED4,
  output logic       LED3,
  output logic       LED2,
  output logic       LED1,
  output logic       LED0
);

  localparam int unsigned NumLeds = 5;
  localparam int unsigned StepW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] LvlMax  = '1;
  localparam logic [StepW-1:0]    StepEnd = StepW'(STEP_DIV - 1);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StFading = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [NumLeds-1:0]  target_q, target_d;
  logic [PWM_BITS-1:0] level_q [NumLeds];
  logic [PWM_BITS-1:0] level_d [NumLeds];
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [StepW-1:0]    step_cnt_q, step_cnt_d;
  logic [NumLeds-1:0]  led_q, led_d;

  logic                step_tick;
  logic                accept;
  logic                all_done;
  logic [PWM_BITS-1:0] goal;

  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    step_tick  = (step_cnt_q == StepEnd);
    // Step timebase is free-running; acceptance never realigns it.
    step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
    accept     = pat_valid && (state_q == StIdle);

    state_d  = state_q;
    target_d = target_q;
    level_d  = level_q;
    all_done = 1'b1;
    goal     = '0;

    if (accept) begin
      target_d = pattern;
      if (pat_snap) begin
        for (int n = 0; n < NumLeds; n++) begin
          level_d[n] = pattern[n] ? LvlMax : '0;
        end
      end else begin
        state_d = StFading;
      end
    end else if ((state_q == StFading) && step_tick) begin
      for (int n = 0; n < NumLeds; n++) begin
        goal = target_q[n] ? LvlMax : '0;
        if (level_q[n] < goal) begin
          level_d[n] = level_q[n] + 1'b1;
        end else if (level_q[n] > goal) begin
          level_d[n] = level_q[n] - 1'b1;
        end
        if (level_d[n] != goal) begin
          all_done = 1'b0;
        end
      end
      // Exit on the tick whose updated levels all sit at their goals.
      if (all_done) begin
        state_d = StIdle;
      end
    end

    for (int n = 0; n < NumLeds; n++) begin
      led_d[n] = (level_q[n] > pwm_cnt_q);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      target_q   <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      led_q      <= '0;
      for (int n = 0; n < NumLeds; n++) begin
        level_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
      for (int n = 0; n < NumLeds; n++) begin
        level_q[n] <= level_d[n];
      end
    end
  end

  assign pat_ready = (state_q == StIdle);
  assign busy      = (state_q == StFading);
  assign LED4      = led_q[4];
  assign LED3      = led_q[3];
  assign LED2      = led_q[2];
  assign LED1      = led_q[1];
  assign LED0      = led_q[0];

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with PWM_BITS=4, STEP_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge. cyc counts rising edges
// since reset release, so step ticks fall on edges where cyc becomes a multiple of 4 and
// pwm_cnt before an edge equals (cyc-1)%16.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] pattern = '0;
  logic       pat_valid = 1'b0;
  logic       pat_snap = 1'b0;
  logic       pat_ready, busy;
  logic       led4, led3, led2, led1, led0;
  logic [4:0] leds;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  assign leds = {led4, led3, led2, led1, led0};

  led_fader #(
    .PWM_BITS(4),
    .STEP_DIV(4)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .pattern  (pattern),
    .pat_valid(pat_valid),
    .pat_snap (pat_snap),
    .pat_ready(pat_ready),
    .busy     (busy),
    .LED4     (led4),
    .LED3     (led3),
    .LED2     (led2),
    .LED1     (led1),
    .LED0     (led0)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [19:0] levels();
    return {dut.level_q[4], dut.level_q[3], dut.level_q[2], dut.level_q[1], dut.level_q[0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (leds !== 5'b0 || pat_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: leds=%b ready=%b busy=%b, want 00000 1 0", leds, pat_ready, busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n_checks++;
      if (leds !== 5'b0 || pat_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_%0d: leds=%b ready=%b busy=%b, want 00000 1 0", i, leds, pat_ready,
                 busy);
      end
    end
  endtask

  task automatic test_snap();
    int hi [5];
    pattern = 5'b10101; pat_snap = 1'b1; pat_valid = 1'b1;
    @(negedge clk);
    pat_valid = 1'b0;
    n_checks += 2;
    if (levels() !== 20'hF0F0F) begin
      n_fail++;
      $display("FAIL snap_levels: got %h, want f0f0f", levels());
    end
    if (leds !== 5'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL snap_first_cycle: leds=%b busy=%b, want 00000 0", leds, busy);
    end
    for (int n = 0; n < 5; n++) hi[n] = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      for (int n = 0; n < 5; n++) hi[n] += int'(leds[n]);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL snap_busy_%0d: busy=%b, want 0", i, busy);
      end
    end
    n_checks++;
    if (hi[4] != 30 || hi[3] != 0 || hi[2] != 30 || hi[1] != 0 || hi[0] != 30) begin
      n_fail++;
      $display("FAIL snap_duty: highs/32 = %0d %0d %0d %0d %0d, want 30 0 30 0 30",
               hi[4], hi[3], hi[2], hi[1], hi[0]);
    end
    // Snap back to all-off for the fade tests.
    pattern = 5'b00000; pat_snap = 1'b1; pat_valid = 1'b1;
    @(negedge clk);
    pat_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (levels() !== 20'h0 || leds !== 5'b0) begin
      n_fail++;
      $display("FAIL snap_off: levels=%h leds=%b, want 00000 00000", levels(), leds);
    end
  endtask

  task automatic test_fade_up();
    int prev, cur, exp_l;
    logic exp_led;
    bit done;
    // Accept off the tick phase so the first step proves step_cnt was not restarted.
    for (int i = 0; i < 4 && (cyc % 4) != 1; i++) @(negedge clk);
    pattern = 5'b00001; pat_snap = 1'b0; pat_valid = 1'b1;
    @(negedge clk);
    pat_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || pat_ready !== 1'b0 || levels() !== 20'h0) begin
      n_fail++;
      $display("FAIL fade_accept: busy=%b ready=%b levels=%h, want 1 0 00000", busy, pat_ready,
               levels());
    end
    prev = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cur = int'(dut.level_q[0]);
      exp_l = ((cyc % 4) == 0) ? prev + 1 : prev;
      exp_led = (prev > ((cyc - 1) % 16));
      n_checks += 3;
      if (cur != exp_l) begin
        n_fail++;
        $display("FAIL fade_up_level: got %0d, want %0d", cur, exp_l);
      end
      if (led0 !== exp_led) begin
        n_fail++;
        $display("FAIL fade_up_led0: got %b, want %b (level %0d)", led0, exp_led, prev);
      end
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fade_up_busy: got %b, want 1", busy);
      end
      prev = cur;
      if (cur == 7) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL fade_up_reach7: level0=%0d, want 7 within 40 cycles", prev);
    end
  endtask

  task automatic test_holdoff();
    int prev, cur, exp_l, ticks;
    bit done;
    // Offer all-off while still fading up; it must wait for IDLE.
    pattern = 5'b00000; pat_snap = 1'b0; pat_valid = 1'b1;
    prev = int'(dut.level_q[0]);
    ticks = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      cur = int'(dut.level_q[0]);
      exp_l = ((cyc % 4) == 0) ? prev + 1 : prev;
      if (cur != prev) ticks++;
      n_checks += 2;
      if (cur != exp_l) begin
        n_fail++;
        $display("FAIL holdoff_level: got %0d, want %0d", cur, exp_l);
      end
      if (cur == 15) begin
        done = 1'b1;
        if (busy !== 1'b0 || pat_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL holdoff_end: busy=%b ready=%b, want 0 1", busy, pat_ready);
        end
      end else if (busy !== 1'b1 || pat_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL holdoff_busy: busy=%b ready=%b, want 1 0", busy, pat_ready);
      end
      prev = cur;
    end
    n_checks++;
    if (!done || ticks != 8) begin
      n_fail++;
      $display("FAIL holdoff_ticks: done=%0d ticks=%0d, want 1 8", done, ticks);
    end
    @(negedge clk);
    pat_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || int'(dut.level_q[0]) != 15) begin
      n_fail++;
      $display("FAIL holdoff_accept: busy=%b level0=%0d, want 1 15", busy, dut.level_q[0]);
    end
    prev = 15;
    ticks = 0;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      cur = int'(dut.level_q[0]);
      exp_l = ((cyc % 4) == 0) ? prev - 1 : prev;
      if (cur != prev) ticks++;
      n_checks += 2;
      if (cur != exp_l) begin
        n_fail++;
        $display("FAIL fade_down_level: got %0d, want %0d", cur, exp_l);
      end
      if (cur == 0) begin
        done = 1'b1;
        if (busy !== 1'b0 || pat_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL fade_down_end: busy=%b ready=%b, want 0 1", busy, pat_ready);
        end
      end else if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fade_down_busy: busy=%b, want 1", busy);
      end
      prev = cur;
    end
    n_checks++;
    if (!done || ticks != 15) begin
      n_fail++;
      $display("FAIL fade_down_ticks: done=%0d ticks=%0d, want 1 15", done, ticks);
    end
  endtask

  task automatic test_zero_fade();
    int waited;
    pattern = 5'b00000; pat_snap = 1'b0; pat_valid = 1'b1;
    @(negedge clk);
    pat_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_fade_busy: got %b, want 1", busy);
    end
    waited = 0;
    while (busy === 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (busy !== 1'b0 || waited > 4 || (cyc % 4) != 0 || levels() !== 20'h0) begin
      n_fail++;
      $display("FAIL zero_fade_exit: busy=%b waited=%0d phase=%0d levels=%h, want 0 <=4 0 00000",
               busy, waited, cyc % 4, levels());
    end
    // Acceptance on a step_tick edge: no step on that edge.
    for (int i = 0; i < 4 && (cyc % 4) != 3; i++) @(negedge clk);
    pattern = 5'b00001; pat_snap = 1'b0; pat_valid = 1'b1;
    @(negedge clk);
    pat_valid = 1'b0;
    n_checks++;
    if (int'(dut.level_q[0]) != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL coincide_accept: level0=%0d busy=%b, want 0 1", dut.level_q[0], busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (int'(dut.level_q[0]) != ((i == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL coincide_step_%0d: level0=%0d, want %0d", i, dut.level_q[0],
                 (i == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (int'(dut.level_q[0]) == 9) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL reset_mid_reach9: level0=%0d, want 9", dut.level_q[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (leds !== 5'b0 || busy !== 1'b0 || pat_ready !== 1'b1 || levels() !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_async: leds=%b busy=%b ready=%b levels=%h, want 00000 0 1 00000",
               leds, busy, pat_ready, levels());
    end
    @(negedge clk);
    rst_n = 1'b1;
    pattern = 5'b10101; pat_snap = 1'b1; pat_valid = 1'b1;
    @(negedge clk);
    pat_valid = 1'b0;
    n_checks++;
    if (levels() !== 20'hF0F0F || busy !== 1'b0 || pat_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reaccept: levels=%h busy=%b ready=%b, want f0f0f 0 1", levels(),
               busy, pat_ready);
    end
    @(negedge clk);
    n_checks++;
    if (leds !== 5'b10101) begin
      n_fail++;
      $display("FAIL reset_reaccept_leds: got %b, want 10101", leds);
    end
  endtask

  initial begin
    test_reset();
    test_snap();
    test_fade_up();
    test_holdoff();
    test_zero_fade();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
